// File: rtl/poker_pkg.sv
// Shared types and helpers for the card table: suits, packed card encoding,
// player command codes, dealer FSM states and deck index -> card mapping.
package poker_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;
  localparam int unsigned RANK_BASE = 2;

  typedef enum logic [1:0] {
    SUIT_CLUBS    = 2'd0,
    SUIT_DIAMONDS = 2'd1,
    SUIT_HEARTS   = 2'd2,
    SUIT_SPADES   = 2'd3
  } suit_e;

  typedef struct packed {
    suit_e      suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_DEAL    = 3'd1,
    CMD_CHECK   = 3'd2,
    CMD_FOLD    = 3'd3,
    CMD_SHUFFLE = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READY,
    ST_EXEC,
    ST_SEARCH,
    ST_ACK
  } state_e;

  // idx 0..51 -> {suit = idx/13, rank = idx%13 + 2}
  function automatic card_t idx_to_card(input logic [5:0] idx);
    card_t c;
    if (idx >= 6'(3 * RANKS)) begin
      c.suit = SUIT_SPADES;
      c.rank = 4'(idx - 6'(3 * RANKS)) + 4'(RANK_BASE);
    end else if (idx >= 6'(2 * RANKS)) begin
      c.suit = SUIT_HEARTS;
      c.rank = 4'(idx - 6'(2 * RANKS)) + 4'(RANK_BASE);
    end else if (idx >= 6'(RANKS)) begin
      c.suit = SUIT_DIAMONDS;
      c.rank = 4'(idx - 6'(RANKS)) + 4'(RANK_BASE);
    end else begin
      c.suit = SUIT_CLUBS;
      c.rank = 4'(idx) + 4'(RANK_BASE);
    end
    return c;
  endfunction

endpackage

// File: rtl/deck_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (x^6 + x^5 + 1) used to pick draw
// candidates. Visits every nonzero value once per 63 steps.
module deck_lfsr #(
  parameter logic [5:0] SEED = 6'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [5:0] seed,
  output logic [5:0] lfsr
);

  // Shift register: reset to SEED, optional explicit load, step when enabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= seed;
    end else if (en) begin
      lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    end
  end

endmodule

// File: rtl/table_dealer.sv
// Table-side dealer: executes player commands against a 52-card deck and
// acknowledges each with a one-cycle cr_ack.
// Build option: DEALER_FIXED_ORDER_EN replaces the LFSR draw with an in-order
// pointer scan over deck indices 0..51.
module table_dealer
  import poker_pkg::*;
#(
  parameter int unsigned HAND_MAX  = 5,
  parameter logic [5:0]  LFSR_SEED = 6'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tbl_new_game,
  output logic       tbl_game_start,
  input  logic       cr_cmdvld,
  input  logic [2:0] cr_cmd,
  output logic       cr_ack,
  output logic [5:0] dl_card,
  output logic       dl_err,
  output logic [5:0] dl_cards_left,
  output logic [2:0] dl_hand_cnt
);

  state_e      state, state_nxt;
  logic [2:0]  cmd_q;
  logic [51:0] mask;
  logic [63:0] mask_ext;
  logic [5:0]  cards_left;
  logic [2:0]  hand_cnt;
  card_t       card_q;
  logic        err_q;
  logic [5:0]  cand_idx;
  logic        cand_hit;
  logic        deal_blocked;
  logic        probe;

`ifdef DEALER_FIXED_ORDER_EN
  logic [5:0] ptr;
  assign cand_idx = ptr;
`else
  logic [5:0] lfsr_q;

  deck_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (probe),
    .load  (1'b0),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr_q)
  );

  assign cand_idx = lfsr_q - 6'd1;
`endif

  // Candidate evaluation; EXEC probes the first candidate of a DEAL so a
  // first-try hit acks in the same cycle as any other command
  always_comb begin
    mask_ext     = {12'b0, mask};
    cand_hit     = (cand_idx < 6'(DECK_SIZE)) && !mask_ext[cand_idx];
    deal_blocked = (cards_left == '0) || (hand_cnt == 3'(HAND_MAX));
    probe        = ((state == ST_EXEC) && (cmd_q == CMD_DEAL) && !deal_blocked)
                   || (state == ST_SEARCH);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tbl_new_game) state_nxt = ST_READY;
      ST_READY:  if (cr_cmdvld) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (cmd_q == CMD_DEAL && !deal_blocked && !cand_hit) state_nxt = ST_SEARCH;
        else                                                 state_nxt = ST_ACK;
      end
      ST_SEARCH: if (cand_hit) state_nxt = ST_ACK;
      ST_ACK:    state_nxt = (cmd_q == CMD_FOLD) ? ST_IDLE : ST_READY;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; a FOLD drops game_start already in its ack cycle
  always_comb begin
    cr_ack         = 1'b0;
    tbl_game_start = 1'b0;
    case (state)
      ST_READY, ST_EXEC, ST_SEARCH: tbl_game_start = 1'b1;
      ST_ACK: begin
        cr_ack         = 1'b1;
        tbl_game_start = (cmd_q != CMD_FOLD);
      end
      default: ;
    endcase
  end

  // Deck, hand and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      mask       <= '0;
      cards_left <= 6'(DECK_SIZE);
      hand_cnt   <= '0;
      card_q     <= '0;
      err_q      <= 1'b0;
`ifdef DEALER_FIXED_ORDER_EN
      ptr        <= '0;
`endif
    end else begin
      if (state == ST_READY && cr_cmdvld) cmd_q <= cr_cmd;
      if (state == ST_IDLE && tbl_new_game) hand_cnt <= '0;
      if (state == ST_EXEC) begin
        case (cmd_q)
          CMD_DEAL: if (deal_blocked) err_q <= 1'b1;
          CMD_SHUFFLE: begin
            mask       <= '0;
            cards_left <= 6'(DECK_SIZE);
            err_q      <= 1'b0;
`ifdef DEALER_FIXED_ORDER_EN
            ptr        <= '0;
`endif
          end
          CMD_NOP, CMD_CHECK, CMD_FOLD: err_q <= 1'b0;
          default: err_q <= 1'b1;
        endcase
      end
      if (probe && cand_hit) begin
        for (int unsigned i = 0; i < DECK_SIZE; i++) begin
          if (cand_idx == 6'(i)) mask[i] <= 1'b1;
        end
        cards_left <= cards_left - 6'd1;
        hand_cnt   <= hand_cnt + 3'd1;
        card_q     <= idx_to_card(cand_idx);
        err_q      <= 1'b0;
`ifdef DEALER_FIXED_ORDER_EN
        ptr        <= ptr + 6'd1;
`endif
      end
    end
  end

  assign dl_card       = card_q;
  assign dl_err        = err_q;
  assign dl_cards_left = cards_left;
  assign dl_hand_cnt   = hand_cnt;

endmodule

// File: tb/tb_table_dealer.sv
// Directed bench for table_dealer. Works for the default (LFSR) build and for
// the DEALER_FIXED_ORDER_EN build.
module tb_table_dealer;
  import poker_pkg::*;

  localparam int HAND_MAX = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tbl_new_game = 1'b0;
  logic       tbl_game_start;
  logic       cr_cmdvld = 1'b0;
  logic [2:0] cr_cmd = '0;
  logic       cr_ack;
  logic [5:0] dl_card;
  logic       dl_err;
  logic [5:0] dl_cards_left;
  logic [2:0] dl_hand_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [5:0]  m_lfsr;
  logic [5:0]  m_ptr;
  logic [51:0] m_mask;
  logic [51:0] seen;
  int          m_left;
  int          m_hand;
  logic [5:0]  m_card;

  always #5 clk = ~clk;

  table_dealer #(.HAND_MAX(HAND_MAX), .LFSR_SEED(6'h2A)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tbl_new_game   (tbl_new_game),
    .tbl_game_start (tbl_game_start),
    .cr_cmdvld      (cr_cmdvld),
    .cr_cmd         (cr_cmd),
    .cr_ack         (cr_ack),
    .dl_card        (dl_card),
    .dl_err         (dl_err),
    .dl_cards_left  (dl_cards_left),
    .dl_hand_cnt    (dl_hand_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4]};
  endfunction

  task automatic model_reset();
    m_lfsr = 6'h2A;
    m_ptr  = '0;
    m_mask = '0;
    seen   = '0;
    m_left = 52;
    m_hand = 0;
    m_card = '0;
  endtask

  task automatic model_shuffle();
    m_mask = '0;
    seen   = '0;
    m_left = 52;
    m_ptr  = '0;
  endtask

  // One successful draw; returns the number of rejected candidates
  task automatic model_deal(output int k);
    int   idx;
    logic hit;
    k = 0; hit = 1'b0; idx = 0;
    while (!hit && k < 100) begin
`ifdef DEALER_FIXED_ORDER_EN
      idx   = int'(m_ptr);
      hit   = !m_mask[idx];
      m_ptr = m_ptr + 6'd1;
`else
      idx    = int'(m_lfsr) - 1;
      hit    = (idx < 52) && !m_mask[idx];
      m_lfsr = lfsr_step(m_lfsr);
`endif
      if (!hit) k++;
    end
    m_mask[idx] = 1'b1;
    m_left--;
    m_hand++;
    m_card = {2'(idx / 13), 4'(idx % 13 + 2)};
  endtask

`ifndef DEALER_FIXED_ORDER_EN
  function automatic int peek_k();
    logic [5:0] l;
    int k;
    l = m_lfsr;
    k = 0;
    while (!((int'(l) - 1 < 52) && !m_mask[int'(l) - 1]) && k < 100) begin
      l = lfsr_step(l);
      k++;
    end
    return k;
  endfunction
`endif

  // Issue a command from READY; returns after the ack cycle, back in READY/IDLE
  task automatic do_cmd(input logic [2:0] c, output int lat, output logic gs_ack);
    bit done;
    cr_cmdvld = 1'b1;
    cr_cmd    = c;
    lat       = 0;
    gs_ack    = 1'b0;
    done      = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 100 && !done; n++) begin
      @(negedge clk);
      if (cr_ack) begin
        lat    = n;
        gs_ack = tbl_game_start;
        done   = 1'b1;
      end
    end
    cr_cmdvld = 1'b0;
    if (!done) check("ack_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic do_new_game();
    tbl_new_game = 1'b1;
    @(negedge clk);
    tbl_new_game = 1'b0;
    m_hand = 0;
    check("newgame_gs", 32'(tbl_game_start), 32'd1);
    check("newgame_hand", 32'(dl_hand_cnt), 32'd0);
  endtask

  task automatic do_fold();
    int   lat;
    logic gs;
    do_cmd(CMD_FOLD, lat, gs);
    check("fold_lat", 32'(lat), 32'd2);
    check("fold_gs_at_ack", 32'(gs), 32'd0);
    check("fold_err", 32'(dl_err), 32'd0);
    check("fold_gs_after", 32'(tbl_game_start), 32'd0);
  endtask

  task automatic do_simple(input string tag, input logic [2:0] c, input logic exp_err);
    int   lat;
    logic gs;
    do_cmd(c, lat, gs);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_err"}, 32'(dl_err), 32'(exp_err));
    check({tag, "_card"}, 32'(dl_card), 32'(m_card));
    check({tag, "_left"}, 32'(dl_cards_left), 32'(m_left));
    check({tag, "_hand"}, 32'(dl_hand_cnt), 32'(m_hand));
  endtask

  task automatic do_deal(input string tag);
    int   lat, k, idx;
    logic gs, exp_err;
    k = 0;
    if (m_left == 0 || m_hand == HAND_MAX) begin
      exp_err = 1'b1;
    end else begin
      exp_err = 1'b0;
      model_deal(k);
    end
    do_cmd(CMD_DEAL, lat, gs);
    check({tag, "_lat"}, 32'(lat), 32'(2 + k));
    check({tag, "_err"}, 32'(dl_err), 32'(exp_err));
    check({tag, "_card"}, 32'(dl_card), 32'(m_card));
    check({tag, "_left"}, 32'(dl_cards_left), 32'(m_left));
    check({tag, "_hand"}, 32'(dl_hand_cnt), 32'(m_hand));
    if (!exp_err) begin
      check({tag, "_lat_max"}, 32'(lat <= 65), 32'd1);
      check({tag, "_legal"}, 32'(dl_card[3:0] >= 4'd2 && dl_card[3:0] <= 4'd14), 32'd1);
      idx = int'(dl_card[5:4]) * 13 + int'(dl_card[3:0]) - 2;
      if (idx >= 0 && idx < 52) begin
        check({tag, "_distinct"}, 32'(seen[idx]), 32'd0);
        seen[idx] = 1'b1;
      end
    end
  endtask

  logic [5:0] exp_first, exp_second;
  bit         ack_seen, found;
  int         lat;
  logic       gs;

  initial begin
`ifdef DEALER_FIXED_ORDER_EN
    exp_first  = 6'h02;   // idx 0: clubs 2
    exp_second = 6'h03;   // idx 1: clubs 3
`else
    exp_first  = 6'h34;   // lfsr 0x2A -> idx 41: spades 4
    exp_second = 6'h19;   // lfsr 0x15 -> idx 20: diamonds 9
`endif
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_gs", 32'(tbl_game_start), 32'd0);
    check("rst_ack", 32'(cr_ack), 32'd0);
    check("rst_card", 32'(dl_card), 32'd0);
    check("rst_err", 32'(dl_err), 32'd0);
    check("rst_left", 32'(dl_cards_left), 32'd52);
    check("rst_hand", 32'(dl_hand_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // command in IDLE is ignored
    cr_cmdvld = 1'b1;
    cr_cmd    = CMD_DEAL;
    ack_seen  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ack_seen |= cr_ack;
    end
    cr_cmdvld = 1'b0;
    check("idle_cmd_noack", 32'(ack_seen), 32'd0);
    check("idle_gs", 32'(tbl_game_start), 32'd0);

    // new_game together with a command: game starts, command dropped
    tbl_new_game = 1'b1;
    cr_cmdvld    = 1'b1;
    @(negedge clk);
    tbl_new_game = 1'b0;
    cr_cmdvld    = 1'b0;
    ack_seen     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ack_seen |= cr_ack;
    end
    check("ng_cmd_noack", 32'(ack_seen), 32'd0);
    check("ng_gs", 32'(tbl_game_start), 32'd1);
    check("ng_left", 32'(dl_cards_left), 32'd52);

    // first two deals
    do_deal("deal1");
    check("deal1_const", 32'(dl_card), 32'(exp_first));
    do_deal("deal2");
    check("deal2_const", 32'(dl_card), 32'(exp_second));
    check("deal2_left", 32'(dl_cards_left), 32'd50);
    check("deal2_hand", 32'(dl_hand_cnt), 32'd2);

    // non-deal commands
    do_simple("nop", CMD_NOP, 1'b0);
    do_simple("check", CMD_CHECK, 1'b0);
    do_simple("illegal6", 3'd6, 1'b1);
    do_simple("check2", CMD_CHECK, 1'b0);

    // fill the hand, then one too many
    do_deal("deal3");
    do_deal("deal4");
    do_deal("deal5");
    do_deal("deal6");
    check("deal6_err_const", 32'(dl_err), 32'd1);
    check("deal6_hand_const", 32'(dl_hand_cnt), 32'd5);
    do_fold();

    // exhaust the deck: 10 hands of 5 plus 2
    for (int h = 0; h < 20 && m_left > 0; h++) begin
      do_new_game();
      while (m_left > 0 && m_hand < HAND_MAX) do_deal("exh");
      if (m_left > 0) do_fold();
    end
    check("exh_left", 32'(dl_cards_left), 32'd0);
    check("exh_hand", 32'(dl_hand_cnt), 32'd2);
    check("exh_all_seen", 32'(&seen), 32'd1);
    do_deal("empty_deal");
    check("empty_err_const", 32'(dl_err), 32'd1);

    // shuffle refills the deck, hand count kept
    model_shuffle();
    do_simple("shuffle", CMD_SHUFFLE, 1'b0);
    check("shuffle_left_const", 32'(dl_cards_left), 32'd52);
    do_deal("post_shuffle");
`ifdef DEALER_FIXED_ORDER_EN
    check("post_shuffle_const", 32'(dl_card), 32'h02);
`endif

    // reset in the middle of a command aborts it
    found = 1'b0;
`ifdef DEALER_FIXED_ORDER_EN
    found = 1'b1;
`else
    for (int it = 0; it < 60 && !found; it++) begin
      if (m_hand == HAND_MAX) begin
        do_fold();
        do_new_game();
      end
      if (peek_k() > 0) found = 1'b1;
      else              do_deal("pre_abort");
    end
`endif
    check("abort_found", 32'(found), 32'd1);
    cr_cmdvld = 1'b1;
    cr_cmd    = CMD_DEAL;
    ack_seen  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ack_seen |= cr_ack;
`ifndef DEALER_FIXED_ORDER_EN
    @(negedge clk);
    ack_seen |= cr_ack;
`endif
    rst_n     = 1'b0;
    cr_cmdvld = 1'b0;
    repeat (2) begin
      @(negedge clk);
      ack_seen |= cr_ack;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ack_seen |= cr_ack;
    end
    model_reset();
    check("abort_noack", 32'(ack_seen), 32'd0);
    check("abort_left", 32'(dl_cards_left), 32'd52);
    check("abort_gs", 32'(tbl_game_start), 32'd0);
    check("abort_card", 32'(dl_card), 32'd0);

    // reset restores the draw sequence
    do_new_game();
    do_deal("rst_deal1");
    check("rst_deal1_const", 32'(dl_card), 32'(exp_first));
    do_cmd(CMD_FOLD, lat, gs);
    check("final_fold_gs", 32'(gs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
